pixel_timing_gen: RTL
=====================

// Module: pixel_timing_gen
// PURPOSE
// - Consumes the 1-clk pixel strobe (flag_pulse) from clockdivider and generates raster timing for the display.
// - Outputs are hsync, vsync, data-enable, x/y position and frame/line markers.
// - Pulls one pixel per active position from the upstream frame buffer via a req/valid handshake.
// - Drives the registered pixel word to the output pins.
// PARAMETERS
// - H_ACTIVE 320 : visible pixels per line
// - H_FP 8 : horizontal front porch, in ticks
// - H_SYNC 32 : hsync width, in ticks
// - H_BP 40 : horizontal back porch, in ticks
// - V_ACTIVE 240 : visible lines per frame
// - V_FP 4 : vertical front porch, in lines
// - V_SYNC 2 : vsync width, in lines
// - V_BP 6 : vertical back porch, in lines
// - SYNC_POL 0 : sync active level (0 = active-low)
// - PIX_W 16 : pixel data width
// PORTS
// - clk          in  1     system clock
// - n_rst        in  1     asynchronous active-low reset
// - enable       in  1     run; low freezes all state
// - pixel_tick   in  1     1-clk strobe from clockdivider.flag_pulse
// - pixel_in     in  PIX_W upstream pixel data, sampled when pixel_valid=1
// - pixel_valid  in  1     1-clk pulse; pixel_in is valid this clk
// - pixel_req    out 1     1-clk request for the next active pixel
// - pixel_out    out PIX_W registered pixel to display
// - hsync        out 1     horizontal sync
// - vsync        out 1     vertical sync
// - de           out 1     data enable (pixel_out is visible)
// - x            out XW    horizontal position, XW=$clog2(H_TOTAL)
// - y            out YW    vertical position, YW=$clog2(V_TOTAL)
// - frame_start  out 1     1-clk pulse on entering (0,0)
// - underflow    out 1     sticky: an active pixel had no data
// BEHAVIOUR
// - Totals: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
// - Reset:
//   - (x,y) = (H_TOTAL-1, V_TOTAL-1)
//   - hsync/vsync = ~SYNC_POL
//   - de, pixel_req, frame_start, underflow = 0; pixel_out = 0; capture buffer empty
// - Advance: on clk where enable & pixel_tick, x <= x+1.
//   - At x=H_TOTAL-1, x wraps to 0 and y increments.
//   - At y=V_TOTAL-1, y wraps to 0.
// - Registered decode: hsync, vsync, de and frame_start are decoded from the next (x,y). They change on the same edge as x,y (0-clk skew).
//   - de=1 iff x<H_ACTIVE and y<V_ACTIVE.
//   - hsync=SYNC_POL iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC. vsync uses the same rule on y.
//   - frame_start=1 for the single clk after the advance into (0,0).
// - Handshake:
//   - pixel_req pulses 1 clk on each advance whose following position is active.
//   - pixel_req also pulses on the first enabled clk after reset, which primes pixel (0,0).
//   - Upstream answers with one pixel_valid pulse before the next tick.
//   - pixel_in is captured into a 1-entry buffer and the buffer is marked full.
// - Consume: on an advance into an active position:
//   - buffer full -> pixel_out <= buffer, buffer emptied.
//   - buffer empty -> pixel_out <= 0 and underflow <= 1.
//   - On an advance into a blank position, pixel_out <= 0.
// - pixel_valid while the buffer is full: the new data is dropped and underflow <= 1.
// - pixel_valid in the same clk as a consuming advance: the buffer drains and the new word loads in that clk. No underflow.
// - enable=0: counters, outputs and buffer hold. pixel_tick is ignored and frame_start/pixel_req are forced 0.
// - pixel_tick with enable=0 is lost; it is not queued.
// - Reset mid-frame: immediate return to reset values. The buffer is discarded and underflow clears.
// - underflow clears only on reset.
// STRUCTURE
// - Package display_pkg:
//   - localparams H_TOTAL, V_TOTAL, XW, YW
//   - typedef region_e {ACTIVE, FRONT, SYNC, BACK}
//   - function region_of(pos, active, fp, sync) shared by the H and V decode
// - Sub-module wrap_counter #(MAX, W): enable, inc, value, wrap.
//   - Instanced twice; the H wrap drives the V inc.
// - Top level holds the decode registers, the capture buffer and the underflow flag.
// TESTING
// Small config: H 4/1/2/1 (H_TOTAL=8), V 3/1/1/1 (V_TOTAL=6), SYNC_POL=0. Ticks every 8 clk from clockdivider.
// 1. Reset release, enable=1, upstream answers every req 2 clk later
//    -> pixel_req on the first clk, first tick gives (0,0).
//    -> frame_start=1 for 1 clk, de=1, pixel_out=first word.
// 2. Full frame
//    -> hsync low for exactly x=5,6 on each line; vsync low only on y=4.
//    -> de=1 for 12 ticks per frame; 12 reqs; underflow=0; frame_start every 48 ticks.
// 3. Withhold pixel_valid for pixel (2,1)
//    -> pixel_out=0 at (2,1), underflow=1 and stays 1, timing unaffected.
// 4. Drop enable for 20 clk at (3,0), with ticks pulsing
//    -> x,y,outputs frozen; resumes at (4,0) on the first tick after re-enable.
// 5. Assert n_rst=0 at (1,2) mid-frame
//    -> all outputs to reset values asynchronously; after release, req prime then (0,0).
// 6. Two pixel_valid pulses between ticks
//    -> second word dropped, underflow=1, pixel_out shows the first word.

Source files
------------

// File: rtl/display_pkg.sv
// Raster geometry defaults, region type and the shared H/V region decode.
package display_pkg;

    localparam int H_TOTAL = 320 + 8 + 32 + 40;
    localparam int V_TOTAL = 240 + 4 + 2 + 6;
    localparam int XW      = $clog2(H_TOTAL);
    localparam int YW      = $clog2(V_TOTAL);

    typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} region_e;

    // Same rule for both axes: active, then front porch, sync, back porch.
    function automatic region_e region_of(input int pos, input int active,
                                          input int fp, input int sync);
        region_e r;
        if (pos < active) begin
            r = ACTIVE;
        end else if (pos < active + fp) begin
            r = FRONT;
        end else if (pos < active + fp + sync) begin
            r = SYNC;
        end else begin
            r = BACK;
        end
        return r;
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-(MAX+1) counter resetting to MAX so the first increment lands on 0.
// wrap is combinational: high in the clk whose increment rolls MAX over to 0.
module wrap_counter #(
    parameter int MAX = 7,
    parameter int W   = 3
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         enable,
    input  logic         inc,
    output logic [W-1:0] value,
    output logic         wrap
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        wrap    = 1'b0;
        if (enable && inc) begin
            if (value_q == MAX_V) begin
                value_d = '0;
                wrap    = 1'b1;
            end else begin
                value_d = value_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            value_q <= MAX_V;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/pixel_timing_gen.sv
// Raster timing generator with a 1-entry pixel capture buffer; all outputs registered, 0-clk skew to x/y.
// Upstream is paced by pixel_req; late data gives a black pixel, surplus data is dropped; both set underflow.
module pixel_timing_gen
    import display_pkg::*;
#(
    parameter int H_ACTIVE = 320,
    parameter int H_FP     = 8,
    parameter int H_SYNC   = 32,
    parameter int H_BP     = 40,
    parameter int V_ACTIVE = 240,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 6,
    parameter int SYNC_POL = 0,
    parameter int PIX_W    = 16,
    localparam int H_TOT   = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOT   = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int X_W     = $clog2(H_TOT),
    localparam int Y_W     = $clog2(V_TOT)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             enable,
    input  logic             pixel_tick,
    input  logic [PIX_W-1:0] pixel_in,
    input  logic             pixel_valid,
    output logic             pixel_req,
    output logic [PIX_W-1:0] pixel_out,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [X_W-1:0]   x,
    output logic [Y_W-1:0]   y,
    output logic             frame_start,
    output logic             underflow
);

    localparam logic SYNC_LVL = (SYNC_POL != 0);

    logic             adv;
    logic             h_wrap;
    logic             v_wrap;
    logic [X_W-1:0]   x_nxt;
    logic [Y_W-1:0]   y_nxt;
    logic             act_nxt;
    region_e          h_reg;
    region_e          v_reg;

    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             de_q, de_d;
    logic             fs_q, fs_d;
    logic             req_q, req_d;
    logic             prime_q, prime_d;
    logic [PIX_W-1:0] pout_q, pout_d;
    logic [PIX_W-1:0] buf_q, buf_d;
    logic             full_q, full_d;
    logic             uflow_q, uflow_d;

    assign adv = enable & pixel_tick;

    wrap_counter #(.MAX(H_TOT - 1), .W(X_W)) u_hcnt (
        .clk    (clk),
        .n_rst  (n_rst),
        .enable (enable),
        .inc    (pixel_tick),
        .value  (x),
        .wrap   (h_wrap)
    );

    wrap_counter #(.MAX(V_TOT - 1), .W(Y_W)) u_vcnt (
        .clk    (clk),
        .n_rst  (n_rst),
        .enable (enable),
        .inc    (h_wrap),
        .value  (y),
        .wrap   (v_wrap)
    );

    // Next position mirrors the counters so the decode lands on the same edge.
    always_comb begin
        x_nxt = x;
        y_nxt = y;
        if (adv) begin
            x_nxt = h_wrap ? '0 : x + 1'b1;
        end
        if (h_wrap) begin
            y_nxt = v_wrap ? '0 : y + 1'b1;
        end
        h_reg   = region_of(32'(x_nxt), H_ACTIVE, H_FP, H_SYNC);
        v_reg   = region_of(32'(y_nxt), V_ACTIVE, V_FP, V_SYNC);
        act_nxt = (h_reg == ACTIVE) && (v_reg == ACTIVE);
    end

    always_comb begin
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        de_d    = de_q;
        fs_d    = 1'b0;
        req_d   = 1'b0;
        prime_d = prime_q;
        pout_d  = pout_q;
        buf_d   = buf_q;
        full_d  = full_q;
        uflow_d = uflow_q;
        if (enable) begin
            prime_d = 1'b0;
            req_d   = prime_q | (adv & act_nxt);
            if (adv) begin
                hsync_d = (h_reg == SYNC) ? SYNC_LVL : ~SYNC_LVL;
                vsync_d = (v_reg == SYNC) ? SYNC_LVL : ~SYNC_LVL;
                de_d    = act_nxt;
                fs_d    = (x_nxt == '0) && (y_nxt == '0);
                pout_d  = '0;
                if (act_nxt) begin
                    if (full_q) begin
                        pout_d = buf_q;
                        full_d = 1'b0;
                    end else begin
                        uflow_d = 1'b1;
                    end
                end
            end
            // Evaluated after the drain so a word arriving on a consuming clk still loads.
            if (pixel_valid) begin
                if (full_d) begin
                    uflow_d = 1'b1;
                end else begin
                    buf_d  = pixel_in;
                    full_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            hsync_q <= ~SYNC_LVL;
            vsync_q <= ~SYNC_LVL;
            de_q    <= 1'b0;
            fs_q    <= 1'b0;
            req_q   <= 1'b0;
            prime_q <= 1'b1;
            pout_q  <= '0;
            buf_q   <= '0;
            full_q  <= 1'b0;
            uflow_q <= 1'b0;
        end else begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            fs_q    <= fs_d;
            req_q   <= req_d;
            prime_q <= prime_d;
            pout_q  <= pout_d;
            buf_q   <= buf_d;
            full_q  <= full_d;
            uflow_q <= uflow_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign frame_start = fs_q;
    assign pixel_req   = req_q;
    assign pixel_out   = pout_q;
    assign underflow   = uflow_q;

endmodule
